// File: rtl/board_reset_seq_pkg.sv
// Shared types for the board reset sequencer: FSM state encoding and lock-loss counter width.
// Also provides a constant max helper for counter sizing.
package board_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   localparam int                    LOST_CNT_W   = 8;
   localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/board_reset_seq_debounce.sv
// Switch debouncer: 2-flop synchroniser, output follows only after DEBOUNCE_CYCLES stable differing samples.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES; output resets to 0 (switch pressed).
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic deb_o
);

   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q, deb_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         // a sample matching the current output restarts the stability window
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == TERM) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: holds PLLs in reset until the switch is released, waits for lock,
// then releases stage resets in index order; lock loss or timeout re-sequences. Outputs registered.
module board_reset_seq
   import board_pkg::*;
#(
   parameter int NUM_LOCKS       = 2,
   parameter int NUM_STAGES      = 3,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int PLL_RST_CYCLES  = 16,
   parameter int LOCK_TIMEOUT    = 65536,
   parameter int LOCK_FILTER     = 4,
   parameter int STAGE_DELAY     = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  switch_reset_n,
   input  logic [NUM_LOCKS-1:0]  pll_locked,
   input  logic                  clear_count,
   output logic                  pll_rst,
   output logic [NUM_STAGES-1:0] stage_reset_n,
   output logic                  all_ready,
   output logic [LOST_CNT_W-1:0] lock_lost_count
);

   localparam int REL_TERM = NUM_STAGES * STAGE_DELAY;
   localparam int CNT_MAX  = max3(PLL_RST_CYCLES - 1, LOCK_TIMEOUT - 1, REL_TERM);
   localparam int CW       = $clog2(CNT_MAX + 1);
   localparam int FW       = $clog2(LOCK_FILTER + 1);

   localparam logic [CW-1:0] PRST_TERM = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_TERM = CW'(LOCK_TIMEOUT - 1);
   localparam logic [FW-1:0] FILT_TERM = FW'(LOCK_FILTER - 1);

   logic                  sw_deb;
   logic [NUM_LOCKS-1:0]  lock_s1_q, lock_s2_q;
   logic [FW-1:0]         filt_q, filt_d;
   logic                  locks_ok, lost, lost_inc;
   seq_state_e            state_q;
   logic [CW-1:0]         cnt_q;
   logic                  pll_rst_q, ready_q;
   logic [NUM_STAGES-1:0] stage_q, stage_hit;
   logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;

   switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sw_deb (
      .clk  (clk),
      .rst  (rst),
      .raw_i(switch_reset_n),
      .deb_o(sw_deb)
   );

   // lost fires on the LOCK_FILTER-th consecutive cycle with any lock low
   always_comb begin
      locks_ok = &lock_s2_q;
      lost     = !locks_ok && (filt_q == FILT_TERM);
      filt_d   = filt_q;
      if (locks_ok) begin
         filt_d = '0;
      end else if (filt_q != FILT_TERM) begin
         filt_d = filt_q + FW'(1);
      end
   end

   always_comb begin
      stage_hit = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_hit[i] = (cnt_q == CW'((i + 1) * STAGE_DELAY - 1));
      end
   end

   assign lost_inc = sw_deb && lost && (state_q == RELEASE || state_q == RUN);

   always_comb begin
      lost_cnt_d = lost_cnt_q;
      if (clear_count) begin
         lost_cnt_d = '0;
      end else if (lost_inc && lost_cnt_q != LOST_CNT_MAX) begin
         lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_s1_q  <= '0;
         lock_s2_q  <= '0;
         filt_q     <= '0;
         lost_cnt_q <= '0;
      end else begin
         lock_s1_q  <= pll_locked;
         lock_s2_q  <= lock_s1_q;
         filt_q     <= filt_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PLL_RESET;
         cnt_q     <= '0;
         pll_rst_q <= 1'b1;
         stage_q   <= '0;
         ready_q   <= 1'b0;
      end else if (!sw_deb) begin
         // switch press wins; staying in PLL_RESET is not a re-entry, cnt just saturates
         if (state_q != PLL_RESET) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            stage_q   <= '0;
            ready_q   <= 1'b0;
         end else if (cnt_q != PRST_TERM) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end else begin
         unique case (state_q)
            PLL_RESET: begin
               if (cnt_q == PRST_TERM) begin
                  state_q   <= WAIT_LOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
                  stage_q   <= '0;
                  ready_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WAIT_LOCK: begin
               if (locks_ok) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
               end else if (cnt_q == WAIT_TERM) begin
                  state_q   <= PLL_RESET;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
                  stage_q   <= '0;
                  ready_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RELEASE: begin
               if (lost) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
                  stage_q <= '0;
                  ready_q <= 1'b0;
               end else if (&stage_q) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
                  stage_q <= stage_q | stage_hit;
               end
            end
            RUN: begin
               if (lost) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
                  stage_q <= '0;
                  ready_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign pll_rst         = pll_rst_q;
   assign stage_reset_n   = stage_q;
   assign all_ready       = ready_q;
   assign lock_lost_count = lost_cnt_q;

endmodule

// File: tb/tb_board_reset_seq.sv
// Bench for board_reset_seq: directed timeline checks plus a cycle reference model driven by
// directed and $urandom stimulus; every comparison is an immediate assertion.
module tb_board_reset_seq;

   localparam int NL = 2, NS = 3, DB = 4, PRC = 3, LT = 20, LF = 2, SD = 8;
   localparam int M_PRST = 0, M_WAIT = 1, M_REL = 2, M_RUN = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          switch_reset_n = 1'b1;
   logic          clear_count = 1'b0;
   logic [NL-1:0] pll_locked = '0;
   logic          pll_rst, all_ready;
   logic [NS-1:0] stage_reset_n;
   logic [7:0]    lock_lost_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   board_reset_seq #(
      .NUM_LOCKS(NL), .NUM_STAGES(NS), .DEBOUNCE_CYCLES(DB), .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT(LT), .LOCK_FILTER(LF), .STAGE_DELAY(SD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .switch_reset_n (switch_reset_n),
      .pll_locked     (pll_locked),
      .clear_count    (clear_count),
      .pll_rst        (pll_rst),
      .stage_reset_n  (stage_reset_n),
      .all_ready      (all_ready),
      .lock_lost_count(lock_lost_count)
   );

   // Reference model: mode + time-in-mode, pin histories for the synchroniser delay
   int            m_mode, m_t, m_cnt, m_run, m_low;
   bit            m_deb, m_s, m_ok, m_lost, m_inc;
   bit            sw_hist[$];
   logic [NL-1:0] lk_hist[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_PRST; m_t = 0; m_cnt = 0; m_run = 0; m_low = 0; m_deb = 1'b0;
         sw_hist.delete(); lk_hist.delete();
         repeat (2) begin sw_hist.push_back(1'b0); lk_hist.push_back('0); end
      end else begin
         m_s    = sw_hist[1];
         m_ok   = (lk_hist[1] == '1);
         m_low  = m_ok ? 0 : ((m_low < LF) ? m_low + 1 : LF);
         m_lost = (m_low >= LF);
         m_inc  = m_deb && m_lost && (m_mode == M_REL || m_mode == M_RUN);
         if (!m_deb) begin
            if (m_mode != M_PRST) begin m_mode = M_PRST; m_t = 0; end
            else m_t++;
         end else begin
            case (m_mode)
               M_PRST: if (m_t >= PRC - 1) begin m_mode = M_WAIT; m_t = 0; end else m_t++;
               M_WAIT: if (m_ok) begin m_mode = M_REL; m_t = 0; end
                       else if (m_t == LT - 1) begin m_mode = M_PRST; m_t = 0; end
                       else m_t++;
               M_REL:  if (m_lost) begin m_mode = M_WAIT; m_t = 0; end
                       else if (m_t == NS * SD) begin m_mode = M_RUN; m_t = 0; end
                       else m_t++;
               default: if (m_lost) begin m_mode = M_WAIT; m_t = 0; end
            endcase
         end
         if (clear_count) m_cnt = 0;
         else if (m_inc && m_cnt < 255) m_cnt++;
         if (m_s != m_deb) begin
            m_run++;
            if (m_run == DB) begin m_deb = m_s; m_run = 0; end
         end else begin
            m_run = 0;
         end
         sw_hist.push_front(switch_reset_n); void'(sw_hist.pop_back());
         lk_hist.push_front(pll_locked);     void'(lk_hist.pop_back());
      end
   end

   function automatic logic [NS-1:0] m_stage();
      logic [NS-1:0] s;
      s = '0;
      if (m_mode == M_RUN) s = '1;
      else if (m_mode == M_REL)
         for (int i = 0; i < NS; i++) s[i] = (m_t >= (i + 1) * SD);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("model_pll_rst", 32'(pll_rst), 32'(m_mode == M_PRST));
      chk("model_stage", 32'(stage_reset_n), 32'(m_stage()));
      chk("model_ready", 32'(all_ready), 32'(m_mode == M_RUN));
      chk("model_count", 32'(lock_lost_count), 32'(m_cnt));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
      chk({tag, "_stage"}, 32'(stage_reset_n), 32'd0);
      chk({tag, "_ready"}, 32'(all_ready), 32'd0);
      chk({tag, "_count"}, 32'(lock_lost_count), 32'd0);
   endtask

   // Power-up timeline: switch debounced after edge 6, WAIT_LOCK at 7, locks high after edge 10
   // reach the FSM at edge 13 (RELEASE); stages at 21/29/37, RUN at 38.
   task automatic powerup(input int abort_k);
      int exp_stage;
      rst = 1'b1; switch_reset_n = 1'b1; pll_locked = '0; clear_count = 1'b0;
      #1;
      chk_reset("pwr_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         exp_stage = (k >= 37) ? 7 : (k >= 29) ? 3 : (k >= 21) ? 1 : 0;
         chk("pwr_pll_rst", 32'(pll_rst), 32'(k < 7));
         chk("pwr_stage", 32'(stage_reset_n), 32'(exp_stage));
         chk("pwr_ready", 32'(all_ready), 32'(k >= 38));
         if (k == 10) pll_locked = '1;
         if (k == abort_k) return;
      end
   endtask

   initial begin
      #1;
      // 1. power-up
      powerup(0);
      chk("t1_count", 32'(lock_lost_count), 32'd0);

      // 3. single-cycle glitch ignored, two-cycle loss counted then re-released
      pll_locked = 2'b10; tick(); pll_locked = 2'b11;
      repeat (6) tick();
      chk("t3_glitch_ready", 32'(all_ready), 32'd1);
      chk("t3_glitch_stage", 32'(stage_reset_n), 32'd7);
      chk("t3_glitch_count", 32'(lock_lost_count), 32'd0);
      pll_locked = 2'b10; tick(); tick(); pll_locked = 2'b11;
      repeat (3) tick();
      chk("t3_loss_ready", 32'(all_ready), 32'd0);
      chk("t3_loss_stage", 32'(stage_reset_n), 32'd0);
      chk("t3_loss_count", 32'(lock_lost_count), 32'd1);
      chk("t3_loss_pll_rst", 32'(pll_rst), 32'd0);
      repeat (30) tick();
      chk("t3_relock_ready", 32'(all_ready), 32'd1);
      chk("t3_relock_stage", 32'(stage_reset_n), 32'd7);

      // 4. switch bounce ignored, sustained press re-enters PLL_RESET
      for (int i = 0; i < 20; i++) begin
         switch_reset_n = ((i / 2) % 2 == 1);
         tick();
         chk("t4_bounce_ready", 32'(all_ready), 32'd1);
      end
      switch_reset_n = 1'b1;
      repeat (2) tick();
      switch_reset_n = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t4_press_pll_rst", 32'(pll_rst), 32'(k >= 7));
         chk("t4_press_ready", 32'(all_ready), 32'(k < 7));
      end
      switch_reset_n = 1'b1;
      repeat (45) tick();
      chk("t4_resume_ready", 32'(all_ready), 32'd1);

      // 5. saturation, then clear coincident with a loss
      clear_count = 1'b1; tick(); clear_count = 1'b0;
      chk("t5_cleared", 32'(lock_lost_count), 32'd0);
      for (int n = 0; n < 256; n++) begin
         pll_locked = 2'b00; repeat (3) tick();
         pll_locked = 2'b11; repeat (5) tick();
         if (n == 0) chk("t5_first_loss", 32'(lock_lost_count), 32'd1);
      end
      chk("t5_saturated", 32'(lock_lost_count), 32'd255);
      pll_locked = 2'b00; repeat (3) tick();
      clear_count = 1'b1; pll_locked = 2'b11;
      tick();
      clear_count = 1'b0;
      chk("t5_clear_wins", 32'(lock_lost_count), 32'd0);
      chk("t5_clear_loss_stage", 32'(stage_reset_n), 32'd0);

      // 6. reset mid-release, then a clean re-sequence
      powerup(30);
      chk("t6_pre_stage", 32'(stage_reset_n), 32'd3);
      rst = 1'b1;
      #1;
      chk_reset("t6_async");
      powerup(0);

      // 2. lock timeout with locks held low: 3-cycle pll_rst pulse every 23 cycles
      rst = 1'b1; pll_locked = '0; switch_reset_n = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         chk("t2_pll_rst", 32'(pll_rst), 32'((k < 7) || ((k - 7) % 23 >= 20)));
         chk("t2_stage", 32'(stage_reset_n), 32'd0);
         chk("t2_count", 32'(lock_lost_count), 32'd0);
      end

      // randomized soak against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) pll_locked = NL'($urandom);
         else if ($urandom_range(0, 7) == 0) pll_locked = '1;
         if ($urandom_range(0, 63) == 0) switch_reset_n = ~switch_reset_n;
         clear_count = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
